// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//
// Serial pattern detector. It watches a 1-bit stream for a runtime-loadable
// PAT_W-bit pattern. The first bit received is pat[PAT_W-1]. Matching can be
// overlapping or can restart after each match, chosen at runtime. Every match
// is flagged on y_out and counted in a wrapping counter.
//
// Optional feature macro: SEQDET_REG_OUT_EN
//   undefined : y_out is combinational (Mealy). It is high in the same cycle
//               as the bit that completes the pattern.
//   defined   : y_out is registered. It is one cycle late and lines up with
//               the match_cnt increment.
//
// Stream handshake: x_valid qualifies x_in. A bit is consumed on a rising
// clock edge only when x_valid=1, pat_load=0 and the FSM is in FILL or
// SEARCH. There is no back-pressure: the detector accepts every qualified
// bit. When x_valid is low, all state is held.
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        asynchronous, active-low reset
//   x_in       serial data bit
//   x_valid    x_in qualifier
//   pat_in     pattern to load (MSB is the first bit received)
//   pat_load   load pat_in and restart the search (discards coincident bit)
//   overlap    1 = overlapping matches, 0 = restart after a match
//   clr_cnt    synchronous clear of match_cnt (wins over a coincident hit)
//   y_out      match flag
//   match_cnt  matches since reset or last clear, wraps modulo 2^CNT_W
//   state_o    current FSM state (debug): 00 IDLE, 01 FILL, 10 SEARCH

module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             pat_load,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FILL    = 2'b01,
    SEARCH  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat;
  logic [PAT_W-2:0]   hist;
  logic [FILL_W-1:0]  fill;

  logic               accept;
  logic               full;
  logic               hit;
  logic [PAT_W-1:0]   window;

  // window is the candidate match. It holds the last PAT_W-1 accepted bits
  // plus the bit now on x_in. Its low PAT_W-1 bits become the next hist.
  assign window = {hist, x_in};
  assign accept = x_valid && !pat_load && (state == FILL || state == SEARCH);
  assign full   = (fill == FILL_MAX);
  assign hit    = accept && full && (window == pat);

  assign state_o = state;

`ifndef SEQDET_REG_OUT_EN
  assign y_out = hit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat       <= '0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
`ifdef SEQDET_REG_OUT_EN
      y_out     <= 1'b0;
`endif
    end else begin
      // hit is already forced low on a pat_load cycle, so the registered
      // flag clears on load without a separate term.
`ifdef SEQDET_REG_OUT_EN
      y_out <= hit;
`endif

      if (clr_cnt) begin
        match_cnt <= '0;
      end else if (hit) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end

      if (pat_load) begin
        pat   <= pat_in;
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else begin
        case (state)
          IDLE: begin
            // Stream is ignored until a pattern has been loaded.
          end
          FILL: begin
            if (accept) begin
              if (!full) begin
                hist <= window[PAT_W-2:0];
                fill <= fill + FILL_W'(1);
              end else if (hit && !overlap) begin
                // Restart. The old history can never take part in a match
                // again, because PAT_W-1 new bits refill hist before the
                // next hit.
                hist <= '0;
                fill <= '0;
              end else begin
                hist  <= window[PAT_W-2:0];
                state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (accept) begin
              if (hit && !overlap) begin
                hist  <= '0;
                fill  <= '0;
                state <= FILL;
              end else begin
                hist <= window[PAT_W-2:0];
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector for the chapter-5 FSM set. It watches a 1-bit serial stream for a runtime-loadable PAT_W-bit pattern, with overlapping or non-overlapping matching selectable at runtime. It flags each match on y_out and counts matches in a wrapping counter. It generalises the fixed five-state Mealy machine to arbitrary pattern width, input qualification and a match statistic.

## Interface

- PAT_W, 4, pattern length in bits; legal range 2..16
- CNT_W, 8, match counter width
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- x_in  input  1  serial data bit
- x_valid  input  1  x_in is sampled only when high
- pat_in  input  PAT_W  pattern; pat_in[PAT_W-1] is the first bit received
- pat_load  input  1  load pat_in, restart the search
- overlap  input  1  1 = overlapping matches, 0 = restart after a match
- clr_cnt  input  1  synchronous clear of match_cnt
- y_out  output  1  match flag
- match_cnt  output  CNT_W  number of matches since reset or last clear
- state_o  output  2  current FSM state (debug)

## Operation

- Registers:
  - pat: PAT_W bits.
  - hist: PAT_W-1 most recent accepted bits, newest in the LSB.
  - fill: count of accepted bits since the last restart, saturating at PAT_W-1.
  - state.
  - match_cnt.
- States: IDLE=2'b00, FILL=2'b01, SEARCH=2'b10; 2'b11 is illegal and returns to IDLE.
- Accepted bit: x_valid=1 and pat_load=0 and state!=IDLE.
- hit = accepted bit and fill==PAT_W-1 and {hist, x_in}==pat.
- IDLE:
  - x_valid is ignored.
  - pat_load -> FILL.
- FILL:
  - An accepted bit shifts into hist and increments fill.
  - An accepted bit with fill==PAT_W-1 evaluates hit, then:
    - hit and overlap=0 -> fill=0, stay in FILL.
    - Otherwise -> SEARCH.
- SEARCH:
  - Every accepted bit shifts into hist and evaluates hit.
  - hit and overlap=0 -> fill=0 and hist cleared, go to FILL.
  - hit and overlap=1 -> stay in SEARCH.
- pat_load in any state:
  - pat<=pat_in, hist<=0, fill<=0, state<=FILL.
  - Any coincident x_valid bit is discarded, and hit is forced to 0.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on each hit and wraps modulo 2^CNT_W.
  - clr_cnt=1 sets it to 0; clr_cnt wins over a coincident hit.
- overlap is sampled per accepted bit, so changing it mid-stream takes effect on the next hit.
- x_valid low holds all state; gaps in the stream are transparent.

## Timing

- Reset values: state=IDLE, pat=0, hist=0, fill=0, match_cnt=0, y_out=0, state_o=2'b00.
- Default build: y_out is combinational (Mealy) and equals hit in the same cycle as the completing bit.
- match_cnt updates on the clk edge that accepts the completing bit, so the new value is visible one cycle after y_out.
- Reset asserted mid-stream clears everything immediately, including a partial match; no match is reported across reset.
- First possible hit after pat_load: the PAT_W-th accepted bit after the load cycle.

## Configuration

- Macro: SEQDET_REG_OUT_EN.
- Defined:
  - y_out is registered: y_out <= hit, giving one-cycle latency.
  - y_out is aligned with the match_cnt increment.
  - Reset value of y_out is 0.
  - A pat_load cycle clears the registered y_out.
- Undefined: Mealy combinational y_out as described above.
- The macro has no other behavioural difference.

## Test plan

- Overlap: PAT_W=4, pattern 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 on consecutive valid cycles.
  - Required: y_out high on bits 4 and 7 only; match_cnt=2.
- Non-overlap: same pattern and stream with overlap=0.
  - Required: y_out high on bit 4 only; match_cnt=1; state is FILL after bit 4.
- Valid gaps: stream 1,0,1,1 with x_valid low for 3 cycles between each bit.
  - Required: a single hit on bit 4; no y_out during the gaps.
- Mid-stream load: send 1,0,1, then pat_load with pat_in=4'b0110 coincident with x_valid, x_in=1.
  - Required: the bit is discarded and state=FILL.
  - Then send 0,1,1,0: y_out on the 4th bit; match_cnt unchanged by the load.
- Reset and clear:
  - Drop rst for 2 ns after 1,0,1 of pattern 1011: all outputs return to 0 and state=IDLE asynchronously.
  - After reloading, assert clr_cnt coincident with a hit: match_cnt=0.
- Wrap, run in both macro builds:
  - CNT_W=2, overlap=1, pattern 4'b1111, stream of 7 ones: hits on bits 4..7 and match_cnt goes 1,2,3,0.
  - With SEQDET_REG_OUT_EN, y_out is delayed exactly 1 cycle.
